bfm_ahbtoapb4: RTL and testbench
================================

BFM_AHBTOAPB4 -- requirements
Module: bfm_ahbtoapb4

Interface
REQ-001 SHALL have parameter NSLV, default 16, number of APB slave selects (1..16).
REQ-002 SHALL have parameter DEC_LSB, default 24, LSB of the 4-bit slave index field HADDR[DEC_LSB+3:DEC_LSB].
REQ-003 SHALL have parameter TIMEOUT, default 0, maximum ACCESS wait cycles before abort (0 = no timeout).
REQ-004 SHALL have port HCLK  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port HRESET  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port HSEL  in  1  AHB slave select.
REQ-007 SHALL have port HADDR  in  32  AHB address.
REQ-008 SHALL have port HTRANS  in  2  AHB transfer type; bit 1 set means NONSEQ/SEQ.
REQ-009 SHALL have port HWRITE  in  1  AHB write flag.
REQ-010 SHALL have port HSIZE  in  3  AHB transfer size (0 byte, 1 half, 2 word).
REQ-011 SHALL have port HWDATA  in  32  AHB write data (data phase).
REQ-012 SHALL have port HREADYIN  in  1  AHB bus ready.
REQ-013 SHALL have port HRDATA  out  32  AHB read data.
REQ-014 SHALL have port HREADYOUT  out  1  AHB slave ready.
REQ-015 SHALL have port HRESP  out  1  AHB error response.
REQ-016 SHALL have port PSEL  out  NSLV  one-hot APB select.
REQ-017 SHALL have port PADDR  out  32  APB address (full HADDR).
REQ-018 SHALL have port PWRITE  out  1  APB write flag.
REQ-019 SHALL have port PENABLE  out  1  APB enable.
REQ-020 SHALL have port PWDATA  out  32  APB write data.
REQ-021 SHALL have port PSTRB  out  4  APB4 byte strobes.
REQ-022 SHALL have port PRDATA  in  32  APB read data.
REQ-023 SHALL have port PREADY  in  1  APB ready.
REQ-024 SHALL have port PSLVERR  in  1  APB slave error.

Function
REQ-025 SHALL implement states IDLE, SETUP, ACCESS, ERR1, ERR2.
REQ-026 SHALL treat the cycle with HSEL=1, HREADYIN=1, HTRANS[1]=1 in IDLE as a valid transfer and register HADDR, HWRITE, HSIZE.
REQ-027 SHALL go to SETUP on a valid transfer with slave index < NSLV, and to ERR1 with all PSEL=0 when the index >= NSLV.
REQ-028 SHALL in SETUP drive PSEL[index]=1, PENABLE=0, HREADYOUT=0, PWDATA=HWDATA (live), then go to ACCESS, capturing HWDATA.
REQ-029 SHALL in ACCESS drive PENABLE=1, PWDATA=captured data, HREADYOUT=PREADY&~PSLVERR (combinational), HRDATA=PRDATA.
REQ-030 SHALL in ACCESS with PREADY=0 hold all APB outputs stable and increment a wait counter.
REQ-031 SHALL on PREADY=1 & PSLVERR=0 complete: go to SETUP if a new valid transfer is sampled that cycle (back-to-back, no IDLE gap), else to IDLE.
REQ-032 SHALL on PREADY=1 & PSLVERR=1 go to ERR1, deasserting PSEL and PENABLE.
REQ-033 SHALL when TIMEOUT>0 and the wait counter reaches TIMEOUT with PREADY=0 abort to ERR1, deasserting PSEL and PENABLE.
REQ-034 SHALL in ERR1 drive HRESP=1, HREADYOUT=0; in ERR2 drive HRESP=1, HREADYOUT=1, then go to IDLE, ignoring any transfer sampled in ERR2.
REQ-035 SHALL drive HREADYOUT=1, HRESP=0 in IDLE.
REQ-036 SHALL generate PSTRB for writes: size 0 -> 4'b0001<<HADDR[1:0]; size 1 -> 4'b0011<<{HADDR[1],1'b0}; size 2 or larger -> 4'b1111; reads -> 4'b0000.
REQ-037 SHALL keep the wait counter width at clog2(TIMEOUT+1) (min 1) and clear it on entry to ACCESS.

Reset
REQ-038 SHALL on HRESET=1 at a clock edge enter IDLE from any state (aborting any transfer) and set PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, HRESP=0, HREADYOUT=1, wait counter=0.

Verification
REQ-039 SHALL verify a word write to 0x0300_0010 with PREADY=1 -> PSEL=16'h0008 for 2 cycles, PENABLE in cycle 2, PWDATA=HWDATA, PSTRB=4'hF, HREADYOUT low 1 cycle.
REQ-040 SHALL verify a byte read at 0x0100_0003 with 3 PREADY-low cycles -> HREADYOUT low 4 cycles, PSTRB=0, HRDATA=PRDATA on completion.
REQ-041 SHALL verify PSLVERR=1 on completion -> HRESP=1 for 2 cycles, HREADYOUT 0 then 1.
REQ-042 SHALL verify NSLV=4 and address 0x0500_0000 -> no PSEL, two-cycle error response.
REQ-043 SHALL verify TIMEOUT=8 with PREADY stuck low -> abort after 8 ACCESS cycles then two-cycle error.
REQ-044 SHALL verify back-to-back writes, plus HRESET asserted during ACCESS -> next cycle IDLE with all outputs at reset values.

Source files
------------

// File: rtl/bfm_ahbtoapb4.sv
// bfm_ahbtoapb4: AHB-Lite slave to APB4 master bridge with 4-bit slave decode,
// optional ACCESS wait timeout and a two-cycle AHB error response.
module bfm_ahbtoapb4 #(
    parameter int NSLV    = 16,
    parameter int DEC_LSB = 24,
    parameter int TIMEOUT = 0
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            HSEL,
    input  logic [31:0]     HADDR,
    input  logic [1:0]      HTRANS,
    input  logic            HWRITE,
    input  logic [2:0]      HSIZE,
    input  logic [31:0]     HWDATA,
    input  logic            HREADYIN,
    output logic [31:0]     HRDATA,
    output logic            HREADYOUT,
    output logic            HRESP,
    output logic [NSLV-1:0] PSEL,
    output logic [31:0]     PADDR,
    output logic            PWRITE,
    output logic            PENABLE,
    output logic [31:0]     PWDATA,
    output logic [3:0]      PSTRB,
    input  logic [31:0]     PRDATA,
    input  logic            PREADY,
    input  logic            PSLVERR
);
    localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, ERR1, ERR2} state_t;
    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic          write_q, write_d;
    logic [2:0]    size_q, size_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          valid, hit, done, tout, act;
    assign valid = HSEL & HREADYIN & HTRANS[1];
    assign hit   = {28'd0, HADDR[DEC_LSB+3 -: 4]} < 32'(NSLV);
    assign done  = state_q == ACCESS && PREADY && !PSLVERR;
    assign tout  = (TIMEOUT > 0) && !PREADY && (wait_q + 1'b1 == WW'(TIMEOUT));
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        wait_d  = wait_q;
        if ((state_q == IDLE || done) && valid) begin
            addr_d  = HADDR;
            write_d = HWRITE;
            size_d  = HSIZE;
        end
        case (state_q)
            IDLE:    state_d = valid ? (hit ? SETUP : ERR1) : IDLE;
            SETUP: begin
                state_d = ACCESS;
                wdata_d = HWDATA;
                wait_d  = '0;
            end
            ACCESS: begin
                wait_d  = PREADY ? wait_q : wait_q + 1'b1;
                state_d = PREADY ? (PSLVERR ? ERR1 : valid ? (hit ? SETUP : ERR1) : IDLE)
                                 : (tout ? ERR1 : ACCESS);
            end
            ERR1:    state_d = ERR2;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            wdata_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            wait_q  <= wait_d;
        end
    end
    assign act       = state_q == SETUP || state_q == ACCESS;
    assign PSEL      = act ? NSLV'(1) << addr_q[DEC_LSB+3 -: 4] : '0;
    assign PADDR     = addr_q;
    assign PWRITE    = write_q;
    assign PENABLE   = state_q == ACCESS;
    assign PWDATA    = state_q == SETUP ? HWDATA : wdata_q;
    // Byte lanes follow the AHB address within the word; reads enable no lanes.
    assign PSTRB     = !write_q ? 4'b0000 :
                       size_q == 3'd0 ? 4'b0001 << addr_q[1:0] :
                       size_q == 3'd1 ? 4'b0011 << {addr_q[1], 1'b0} : 4'b1111;
    assign HRDATA    = state_q == ACCESS ? PRDATA : '0;
    assign HREADYOUT = state_q == IDLE || state_q == ERR2 || done;
    assign HRESP     = state_q == ERR1 || state_q == ERR2;
endmodule

// File: tb/tb_bfm_ahbtoapb4.sv
// tb_bfm_ahbtoapb4: lockstep bench driving two bridge configurations (16 slaves/no timeout,
// 4 slaves/timeout 8) and checking each cycle against a transfer-level model.
module tb_bfm_ahbtoapb4;
    logic        clk = 1'b0, rst = 1'b1;
    logic        hsel = 0, hwrite = 0, hreadyin = 1, pready = 0, pslverr = 0;
    logic [31:0] haddr = 0, hwdata = 0, prdata = 0;
    logic [1:0]  htrans = 0;
    logic [2:0]  hsize = 0;
    logic [31:0] a_hrdata, b_hrdata, a_paddr, b_paddr, a_pwdata, b_pwdata;
    logic        a_hready, b_hready, a_hresp, b_hresp, a_pwrite, b_pwrite, a_pen, b_pen;
    logic [15:0] a_psel;
    logic [3:0]  b_psel, a_pstrb, b_pstrb;
    logic [31:0] o_hrdata, o_paddr, o_pwdata;
    logic        o_hready, o_hresp, o_pwrite, o_pen;
    logic [15:0] o_psel;
    logic [3:0]  o_pstrb;
    bit          sel = 0;
    int          errs = 0, checks = 0;
    typedef struct {
        logic [31:0] addr, wdata, rdata;
        logic        wr;
        logic [2:0]  size;
        int          waits;
        bit          err;
    } xfer_t;
    xfer_t xq[$];

    always #5 clk = ~clk;

    bfm_ahbtoapb4 dut_a (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
        .HSIZE(hsize), .HWDATA(hwdata), .HREADYIN(hreadyin), .HRDATA(a_hrdata), .HREADYOUT(a_hready),
        .HRESP(a_hresp), .PSEL(a_psel), .PADDR(a_paddr), .PWRITE(a_pwrite), .PENABLE(a_pen),
        .PWDATA(a_pwdata), .PSTRB(a_pstrb), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr));
    bfm_ahbtoapb4 #(.NSLV(4), .DEC_LSB(24), .TIMEOUT(8)) dut_b (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
        .HSIZE(hsize), .HWDATA(hwdata), .HREADYIN(hreadyin), .HRDATA(b_hrdata), .HREADYOUT(b_hready),
        .HRESP(b_hresp), .PSEL(b_psel), .PADDR(b_paddr), .PWRITE(b_pwrite), .PENABLE(b_pen),
        .PWDATA(b_pwdata), .PSTRB(b_pstrb), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr));

    assign o_hrdata = sel ? b_hrdata : a_hrdata;
    assign o_paddr  = sel ? b_paddr : a_paddr;
    assign o_pwdata = sel ? b_pwdata : a_pwdata;
    assign o_hready = sel ? b_hready : a_hready;
    assign o_hresp  = sel ? b_hresp : a_hresp;
    assign o_pwrite = sel ? b_pwrite : a_pwrite;
    assign o_pen    = sel ? b_pen : a_pen;
    assign o_psel   = sel ? {12'd0, b_psel} : a_psel;
    assign o_pstrb  = sel ? b_pstrb : a_pstrb;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        hsel = 0; htrans = 2'b00; pready = 0; pslverr = 0; hreadyin = 1;
    endtask

    task automatic addr_phase(input xfer_t t);
        hsel = 1; htrans = 2'b10; haddr = t.addr; hwrite = t.wr; hsize = t.size;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1; step(); step(); rst = 0;
    endtask

    // Lanes touched = 2**size bytes at the naturally aligned offset within the word.
    function automatic logic [3:0] exp_strb(input xfer_t t);
        int bytes, lane;
        bytes = t.size >= 3'd2 ? 4 : (1 << t.size);
        lane  = int'(t.addr[1:0]) & ~(bytes - 1);
        return t.wr ? 4'(((1 << bytes) - 1) << lane) : 4'b0000;
    endfunction

    function automatic xfer_t mk(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                                 input int waits, input bit err);
        xfer_t t;
        t.addr = addr; t.wr = wr; t.size = size; t.waits = waits; t.err = err;
        t.wdata = $urandom; t.rdata = $urandom;
        return t;
    endfunction

    task automatic err_path(input string tag);
        xfer_t legal;
        legal = mk(32'h0000_0000, 1'b1, 3'd2, 0, 0);
        look();
        checks++;
        if ({o_hresp, o_hready, o_pen, o_psel} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
            errs++;
            $display("FAIL %s_err1 {hresp,hready,penable,psel} got=%h want=%h", tag,
                     {o_hresp, o_hready, o_pen, o_psel}, {1'b1, 1'b0, 1'b0, 16'h0});
        end
        step();
        addr_phase(legal);
        look();
        checks++;
        if ({o_hresp, o_hready} !== 2'b11) begin
            errs++;
            $display("FAIL %s_err2 {hresp,hready} got=%b want=11", tag, {o_hresp, o_hready});
        end
        step();
        idle_inputs();
        look();
        checks++;
        if ({o_hresp, o_hready, o_psel} !== {1'b0, 1'b1, 16'h0}) begin
            errs++;
            $display("FAIL %s_after_err {hresp,hready,psel} got=%h want=%h", tag,
                     {o_hresp, o_hready, o_psel}, {1'b0, 1'b1, 16'h0});
        end
        step();
    endtask

    task automatic run(input bit b2b, input int nslv, input int tmo, input string tag);
        xfer_t t;
        int    idx, nacc;
        bit    abort, last;
        for (int i = 0; i < xq.size(); i++) begin
            t     = xq[i];
            idx   = int'(t.addr[27:24]);
            abort = tmo > 0 && t.waits >= tmo;
            nacc  = abort ? tmo : t.waits + 1;
            if (i == 0 || !b2b) begin
                addr_phase(t);
                look();
                checks++;
                if ({o_hready, o_hresp} !== 2'b10) begin
                    errs++;
                    $display("FAIL %s_idle {hready,hresp} got=%b want=10", tag, {o_hready, o_hresp});
                end
                step();
            end
            idle_inputs();
            hwdata = t.wdata;
            if (idx >= nslv) begin
                err_path({tag, "_decode"});
                continue;
            end
            look();
            checks++;
            if ({o_psel, o_pen, o_hready, o_pwdata, o_paddr, o_pwrite, o_pstrb} !==
                {16'(1 << idx), 1'b0, 1'b0, t.wdata, t.addr, t.wr, exp_strb(t)}) begin
                errs++;
                $display("FAIL %s_setup {psel,pen,hrdy,pwdata,paddr,pwrite,pstrb} got=%h want=%h", tag,
                         {o_psel, o_pen, o_hready, o_pwdata, o_paddr, o_pwrite, o_pstrb},
                         {16'(1 << idx), 1'b0, 1'b0, t.wdata, t.addr, t.wr, exp_strb(t)});
            end
            step();
            hwdata = $urandom;
            for (int k = 0; k < nacc; k++) begin
                last    = !abort && k == nacc - 1;
                pready  = last;
                pslverr = last && t.err;
                prdata  = last ? t.rdata : $urandom;
                if (last && b2b && i + 1 < xq.size()) addr_phase(xq[i + 1]);
                look();
                checks++;
                if ({o_psel, o_pen, o_hready, o_pwdata, o_paddr, o_pstrb} !==
                    {16'(1 << idx), 1'b1, last && !t.err, t.wdata, t.addr, exp_strb(t)}) begin
                    errs++;
                    $display("FAIL %s_access%0d {psel,pen,hrdy,pwdata,paddr,pstrb} got=%h want=%h", tag, k,
                             {o_psel, o_pen, o_hready, o_pwdata, o_paddr, o_pstrb},
                             {16'(1 << idx), 1'b1, last && !t.err, t.wdata, t.addr, exp_strb(t)});
                end
                if (last && !t.err && !t.wr) begin
                    checks++;
                    if (o_hrdata !== t.rdata) begin
                        errs++;
                        $display("FAIL %s_hrdata got=%h want=%h", tag, o_hrdata, t.rdata);
                    end
                end
                step();
                idle_inputs();
            end
            if (abort || t.err) err_path(abort ? {tag, "_timeout"} : {tag, "_slverr"});
        end
        xq.delete();
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            do_reset();
            look();
            checks++;
            if ({o_psel, o_pen, o_pwrite, o_paddr, o_pwdata, o_pstrb, o_hresp, o_hready} !==
                {16'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1}) begin
                errs++;
                $display("FAIL reset_state dut%0d got=%h want=%h", s,
                         {o_psel, o_pen, o_pwrite, o_paddr, o_pwdata, o_pstrb, o_hresp, o_hready},
                         {16'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1});
            end
        end
    endtask

    task automatic test_word_write();
        sel = 0; do_reset();
        xq.push_back(mk(32'h0300_0010, 1'b1, 3'd2, 0, 0));
        run(0, 16, 0, "word_write");
    endtask

    task automatic test_byte_read();
        sel = 0; do_reset();
        xq.push_back(mk(32'h0100_0003, 1'b0, 3'd0, 3, 0));
        run(0, 16, 0, "byte_read");
    endtask

    task automatic test_slverr();
        sel = 0; do_reset();
        xq.push_back(mk(32'h0200_0002, 1'b1, 3'd1, 1, 1));
        xq.push_back(mk(32'h0700_0000, 1'b0, 3'd2, 0, 1));
        run(0, 16, 0, "slverr");
    endtask

    task automatic test_decode_err();
        sel = 1; do_reset();
        xq.push_back(mk(32'h0500_0000, 1'b1, 3'd2, 0, 0));
        xq.push_back(mk(32'h0300_0000, 1'b1, 3'd2, 0, 0));
        xq.push_back(mk(32'h0F00_0004, 1'b0, 3'd2, 0, 0));
        run(0, 4, 8, "decode");
    endtask

    task automatic test_timeout();
        sel = 1; do_reset();
        xq.push_back(mk(32'h0200_0000, 1'b1, 3'd2, 30, 0));
        xq.push_back(mk(32'h0100_0001, 1'b1, 3'd0, 7, 0));
        run(0, 4, 8, "timeout");
    endtask

    task automatic test_back_to_back();
        sel = 0; do_reset();
        xq.push_back(mk(32'h0300_0010, 1'b1, 3'd2, 0, 0));
        xq.push_back(mk(32'h0A00_0006, 1'b1, 3'd1, 2, 0));
        xq.push_back(mk(32'h0000_0001, 1'b1, 3'd0, 0, 0));
        xq.push_back(mk(32'h0F00_0008, 1'b0, 3'd2, 1, 0));
        run(1, 16, 0, "b2b");
    endtask

    task automatic test_reset_in_access();
        sel = 0; do_reset();
        addr_phase(mk(32'h0200_0004, 1'b1, 3'd2, 0, 0));
        step();
        idle_inputs();
        hwdata = 32'hDEAD_BEEF;
        step();
        look();
        checks++;
        if (o_pen !== 1'b1) begin
            errs++;
            $display("FAIL rst_access_pen got=%b want=1", o_pen);
        end
        rst = 1;
        step();
        rst = 0;
        look();
        checks++;
        if ({o_psel, o_pen, o_pwrite, o_paddr, o_pwdata, o_pstrb, o_hresp, o_hready} !==
            {16'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1}) begin
            errs++;
            $display("FAIL rst_access_state got=%h want=%h",
                     {o_psel, o_pen, o_pwrite, o_paddr, o_pwdata, o_pstrb, o_hresp, o_hready},
                     {16'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1});
        end
        step();
    endtask

    task automatic test_random();
        sel = 0; do_reset();
        for (int i = 0; i < 40; i++)
            xq.push_back(mk($urandom, 1'($urandom), 3'($urandom_range(0, 2)), $urandom_range(0, 3),
                            $urandom_range(0, 4) == 0));
        run(0, 16, 0, "rand_a");
        sel = 1; do_reset();
        for (int i = 0; i < 30; i++)
            xq.push_back(mk({4'($urandom), 4'($urandom_range(0, 5)), 24'($urandom)}, 1'($urandom),
                            3'($urandom_range(0, 3)), $urandom_range(0, 10), $urandom_range(0, 4) == 0));
        run(0, 4, 8, "rand_b");
        sel = 0; do_reset();
        for (int i = 0; i < 20; i++)
            xq.push_back(mk($urandom, 1'($urandom), 3'($urandom_range(0, 2)), $urandom_range(0, 3), 0));
        run(1, 16, 0, "rand_b2b");
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_byte_read();
        test_slverr();
        test_decode_err();
        test_timeout();
        test_back_to_back();
        test_reset_in_access();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
